// File: rtl/tap_sum_pkg.sv
// Shared constants and types for the 8-tap summing/averaging pipeline.
package tap_sum_pkg;

    localparam int unsigned N_TAPS     = 8;
    localparam int unsigned PIPE_LAT   = 3;
    localparam logic [3:0]  FILL_MAX   = 4'd8;
    localparam int unsigned DEF_DATA_W = 16;

    typedef logic [N_TAPS-1:0][DEF_DATA_W-1:0] tap_vec_t;

    function automatic int unsigned sum_w(input int unsigned data_w);
        return data_w + 3;
    endfunction

endpackage

// File: rtl/tap_sum_avg8_add_stage.sv
// One registered level of the adder tree: N_OUT pair sums, each one bit wider
// than its inputs, with a valid bit that clear forces low.
module tap_add_stage #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned N_OUT = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            clear,
    input  logic                            in_valid,
    input  logic [2*N_OUT-1:0][IN_W-1:0]    in_data,
    output logic [N_OUT-1:0][IN_W:0]        out_data,
    output logic                            out_valid
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            // Data keeps flowing through clear; only the valid bit is squashed.
            out_valid <= in_valid & ~clear;
            for (int unsigned i = 0; i < N_OUT; i++) begin
                out_data[i] <= {1'b0, in_data[2*i]} + {1'b0, in_data[2*i+1]};
            end
        end
    end

endmodule

// File: rtl/tap_sum_avg8.sv
// Sums eight delay-line taps through a 3-stage registered tree; emits sum, floor mean,
// threshold flag and a warm-up-qualified valid. Optional peak tracker: TAP_PEAK_EN.
module tap_sum_avg8
    import tap_sum_pkg::*;
#(
    parameter int unsigned       DATA_W = 16,
    parameter logic [DATA_W-1:0] THRESH = 16'h8000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic [DATA_W-1:0] tap_a,
    input  logic [DATA_W-1:0] tap_b,
    input  logic [DATA_W-1:0] tap_c,
    input  logic [DATA_W-1:0] tap_d,
    input  logic [DATA_W-1:0] tap_e,
    input  logic [DATA_W-1:0] tap_f,
    input  logic [DATA_W-1:0] tap_g,
    input  logic [DATA_W-1:0] tap_h,
    output logic [DATA_W+2:0] sum_out,
    output logic [DATA_W-1:0] avg_out,
    output logic              over_thresh,
    output logic              out_valid
`ifdef TAP_PEAK_EN
    ,
    output logic [DATA_W-1:0] peak_out
`endif
);

    localparam int unsigned SW = sum_w(DATA_W);

    logic [3:0]                     fill_cnt;
    logic                           taps_full;
    logic [N_TAPS-1:0][DATA_W-1:0]  taps;
    logic [3:0][DATA_W:0]           s1;
    logic                           v1;
    logic [1:0][DATA_W+1:0]         s2;
    logic                           v2;
    logic [SW-1:0]                  s3_next;

    assign taps = {tap_h, tap_g, tap_f, tap_e, tap_d, tap_c, tap_b, tap_a};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_cnt <= '0;
        end else if (clear) begin
            fill_cnt <= '0;
        end else if (fill_cnt != FILL_MAX) begin
            fill_cnt <= fill_cnt + 4'd1;
        end
    end

    assign taps_full = (fill_cnt == FILL_MAX);

    tap_add_stage #(.IN_W(DATA_W), .N_OUT(4)) u_stage1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .in_valid  (taps_full),
        .in_data   (taps),
        .out_data  (s1),
        .out_valid (v1)
    );

    tap_add_stage #(.IN_W(DATA_W+1), .N_OUT(2)) u_stage2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .in_valid  (v1),
        .in_data   (s1),
        .out_data  (s2),
        .out_valid (v2)
    );

    assign s3_next = {1'b0, s2[0]} + {1'b0, s2[1]};

    // Mean and threshold come from the final sum before it is registered,
    // so all three outputs change on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_out     <= '0;
            avg_out     <= '0;
            over_thresh <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            sum_out     <= s3_next;
            avg_out     <= s3_next[SW-1:3];
            over_thresh <= (s3_next[SW-1:3] >= THRESH);
            out_valid   <= v2 & ~clear;
        end
    end

`ifdef TAP_PEAK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            peak_out <= '0;
        end else if (clear) begin
            peak_out <= '0;
        end else if (out_valid && (avg_out > peak_out)) begin
            peak_out <= avg_out;
        end
    end
`endif

endmodule

// File: tb/tb_tap_sum_avg8.sv
// Table-driven bench for tap_sum_avg8 with an expected-result queue and an edge-count valid model.
module tb_tap_sum_avg8;
    import tap_sum_pkg::*;

    typedef struct {
        tap_vec_t    taps;
        logic        clr;
        logic [18:0] exp_sum;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    tap_vec_t    cur_taps = '0;
    logic [15:0] tap_a, tap_b, tap_c, tap_d, tap_e, tap_f, tap_g, tap_h;
    logic [18:0] sum_out;
    logic [15:0] avg_out;
    logic        over_thresh;
    logic        out_valid;
`ifdef TAP_PEAK_EN
    logic [15:0] peak_out;
`endif

    assign tap_a = cur_taps[0];
    assign tap_b = cur_taps[1];
    assign tap_c = cur_taps[2];
    assign tap_d = cur_taps[3];
    assign tap_e = cur_taps[4];
    assign tap_f = cur_taps[5];
    assign tap_g = cur_taps[6];
    assign tap_h = cur_taps[7];

    tap_sum_avg8 #(.DATA_W(16), .THRESH(16'h8000)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .tap_a       (tap_a),
        .tap_b       (tap_b),
        .tap_c       (tap_c),
        .tap_d       (tap_d),
        .tap_e       (tap_e),
        .tap_f       (tap_f),
        .tap_g       (tap_g),
        .tap_h       (tap_h),
        .sum_out     (sum_out),
        .avg_out     (avg_out),
        .over_thresh (over_thresh),
        .out_valid   (out_valid)
`ifdef TAP_PEAK_EN
        ,
        .peak_out    (peak_out)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [18:0] q[$];
    int unsigned edge_cnt = 0;
    logic        prev_valid = 1'b0;
    logic [15:0] prev_avg = '0;
    logic [15:0] peak_exp = '0;
    vec_t        vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic tap_vec_t fill(input logic [15:0] val);
        tap_vec_t v;
        for (int i = 0; i < 8; i++) v[i] = val;
        return v;
    endfunction

    function automatic logic [18:0] sum8(input tap_vec_t v);
        logic [18:0] s = '0;
        for (int i = 0; i < 8; i++) s = s + {3'b000, v[i]};
        return s;
    endfunction

    // Drive taps after one edge; they are sampled on the next and emerge two edges later.
    task automatic step(input tap_vec_t tv, input logic clr, input logic [18:0] es);
        logic [18:0] e;
        logic        ev;
        @(negedge clk);
        cur_taps = tv;
        clear    = clr;
        q.push_back(es);
        @(posedge clk);
        #1;
        if (clr) peak_exp = '0;
        else if (prev_valid && (prev_avg > peak_exp)) peak_exp = prev_avg;
        if (clr) edge_cnt = 0;
        else if (edge_cnt < 15) edge_cnt++;
        ev = (edge_cnt >= 11);
        e  = q.pop_front();
        chk("sum_out", {13'd0, sum_out}, {13'd0, e});
        chk("avg_out", {16'd0, avg_out}, {16'd0, e[18:3]});
        chk("over_thresh", {31'd0, over_thresh}, {31'd0, (e[18:3] >= 16'h8000)});
        chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
`ifdef TAP_PEAK_EN
        chk("peak_out", {16'd0, peak_out}, {16'd0, peak_exp});
`endif
        prev_valid = ev;
        prev_avg   = e[18:3];
    endtask

    task automatic do_reset(input logic midstream);
        if (midstream) begin
            #2;
            reset_n = 1'b0;
            #1;
            chk("async_rst_sum", {13'd0, sum_out}, 32'd0);
            chk("async_rst_avg", {16'd0, avg_out}, 32'd0);
            chk("async_rst_over", {31'd0, over_thresh}, 32'd0);
            chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
`ifdef TAP_PEAK_EN
            chk("async_rst_peak", {16'd0, peak_out}, 32'd0);
`endif
        end else begin
            reset_n = 1'b0;
        end
        cur_taps = '0;
        clear    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_sum", {13'd0, sum_out}, 32'd0);
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        reset_n = 1'b1;
        q.delete();
        q.push_back('0);
        q.push_back('0);
        edge_cnt   = 0;
        prev_valid = 1'b0;
        prev_avg   = '0;
        peak_exp   = '0;
    endtask

    initial begin
        tap_vec_t seq;
        tap_vec_t abcd;
        int       n;

        abcd = fill(16'hABCD);
        for (int i = 0; i < 8; i++) seq[i] = 16'(i + 1);
        for (int i = 0; i < 20; i++) vecs.push_back('{abcd, 1'b0, 19'h55E68});
        for (int i = 0; i < 4; i++)  vecs.push_back('{seq, 1'b0, 19'd36});
        for (int i = 0; i < 4; i++)  vecs.push_back('{fill(16'hFFFF), 1'b0, 19'h7FFF8});
        for (int i = 0; i < 10; i++) begin
            tap_vec_t r;
            for (int j = 0; j < 8; j++) r[j] = 16'($urandom_range(0, 65535));
            vecs.push_back('{r, 1'b0, sum8(r)});
        end

        do_reset(1'b0);
        for (int i = 0; i < vecs.size(); i++) step(vecs[i].taps, vecs[i].clr, vecs[i].exp_sum);

        // Single-cycle clear while valid, then count edges until valid returns.
        for (int i = 0; i < 6; i++) step(abcd, 1'b0, 19'h55E68);
        step(abcd, 1'b1, 19'h55E68);
        chk("clear_drop", {31'd0, out_valid}, 32'd0);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            step(abcd, 1'b0, 19'h55E68);
            n++;
            if (out_valid) break;
        end
        chk("clear_recover_edges", n, 32'd11);

        // Clear held across many edges.
        for (int i = 0; i < 14; i++) step(seq, 1'b1, 19'd36);
        for (int i = 0; i < 12; i++) step(seq, 1'b0, 19'd36);

        // Asynchronous reset between edges, then the warm-up repeats.
        do_reset(1'b1);
        for (int i = 0; i < 13; i++) step(abcd, 1'b0, 19'h55E68);
        chk("rewarm_valid", {31'd0, out_valid}, 32'd1);

`ifdef TAP_PEAK_EN
        do_reset(1'b0);
        for (int i = 0; i < 12; i++) step(fill(16'h1000), 1'b0, 19'h08000);
        for (int i = 0; i < 4; i++)  step(fill(16'h9000), 1'b0, 19'h48000);
        for (int i = 0; i < 6; i++)  step(fill(16'h2000), 1'b0, 19'h10000);
        chk("peak_hold", {16'd0, peak_out}, 32'h9000);
        step(fill(16'h2000), 1'b1, 19'h10000);
        chk("peak_clear", {16'd0, peak_out}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
